// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges stage stall requests into sign_stall, runs the
// multi-cycle divide hold, generates exception flushes and counts stall cycles.
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             div_start,
    input  logic             exc_valid,
    input  logic [31:0]      exc_vector,
    output logic [5:0]       sign_stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             div_busy,
    output logic             div_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // The start cycle is one of the DIV_CYCLES hold cycles, so BUSY lasts
    // DIV_CYCLES-1 unfrozen cycles.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    div_state_t state, state_next;
    logic [5:0] cnt, cnt_next;
    logic       div_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = DIV_IDLE;
            cnt_next   = 6'd0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_start) begin
                        state_next = DIV_BUSY;
                        cnt_next   = DIV_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (!stallreq_mem) begin
                        if (cnt <= 6'd1) begin
                            state_next = DIV_DONE;
                            cnt_next   = 6'd0;
                        end else begin
                            cnt_next = cnt - 6'd1;
                        end
                    end
                end
                DIV_DONE: state_next = DIV_IDLE;
                default: begin
                    state_next = DIV_IDLE;
                    cnt_next   = 6'd0;
                end
            endcase
        end
    end

    always_comb begin
        div_busy  = (state == DIV_BUSY);
        div_ready = (state == DIV_DONE) && !flush;
        div_hold  = (state == DIV_BUSY) || ((state == DIV_IDLE) && div_start);
    end

    always_comb begin
        sign_stall = 6'b000000;
        if (rst || flush)                  sign_stall = 6'b000000;
        else if (stallreq_mem)             sign_stall = 6'b011111;
        else if (stallreq_ex || div_hold)  sign_stall = 6'b001111;
        else if (stallreq_id)              sign_stall = 6'b000111;
        else if (stallreq_if)              sign_stall = 6'b000011;
    end

    // Exception redirect: new_pc keeps the last accepted vector after the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush  <= 1'b0;
            new_pc <= 32'd0;
        end else begin
            flush <= exc_valid;
            if (exc_valid) new_pc <= exc_vector;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((sign_stall != 6'b000000) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
